// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
// -----------------------------------------------------------------------------
// Purpose:
//   Bundles every handshake and bus signal of the load/store sequencer into a
//   single interface, so the sequencer and its surroundings connect with one
//   port.
//
// Signal groups:
//   in_*   request channel from the execute stage (valid/ready handshake)
//   mem_*  data-memory bus (request/grant, then response/acknowledge)
//   out_*  completion channel back to the execute stage's load extractor
//
// Modports:
//   master  the sequencer itself: it masters the memory bus, accepts requests
//           and produces completions
//   slave   the surroundings: execute stage plus data memory
//
// Parameters:
//   DATA_LEN  datapath width, 32 or 64
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
  parameter int DATA_LEN = 32
);

  // Request channel from the execute stage
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_LEN-1:0]   in_addr;
  logic [DATA_LEN-1:0]   in_wdata;
  logic                  in_is_load;
  logic                  in_is_store;
  logic [1:0]            in_size;

  // Data-memory bus
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_LEN-1:0]   mem_addr;
  logic [DATA_LEN-1:0]   mem_wdata;
  logic [DATA_LEN/8-1:0] mem_wstrb;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_LEN-1:0]   mem_rdata;

  // Completion channel
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_LEN-1:0]   out_pre_data;
  logic                  out_misalign;

  modport master (
    input  in_valid, in_addr, in_wdata, in_is_load, in_is_store, in_size,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output out_valid, out_pre_data, out_misalign,
    input  out_ready
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_is_load, in_is_store, in_size,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  out_valid, out_pre_data, out_misalign,
    output out_ready
  );

endinterface : lsu_ctrl_if

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// -----------------------------------------------------------------------------
// Purpose:
//   Memory-access sequencer sitting directly upstream of the execute stage's
//   load path. It takes one effective address at a time, runs a single
//   request/grant/response transaction on the data-memory bus and returns the
//   loaded word shifted right by the byte offset (raw, not extended) so the
//   load extractor downstream only has to sign- or zero-extend it. Stores get
//   their data shifted into the addressed byte lanes with matching strobes.
//   At most one transaction is ever in flight.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         lsu_ctrl_if.master:
//                 in_*   request from the execute stage
//                 mem_*  data-memory bus
//                 out_*  completion (pre_data / misalign flag)
//
// Parameters:
//   DATA_LEN  datapath width, 32 or 64
//   OFF_W     byte-offset width inside a data word
//
// Build option:
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned half/word/dword requests
//                          never reach the bus; they complete immediately with
//                          out_misalign=1 and out_pre_data=0. When undefined,
//                          out_misalign is tied to 0 and misaligned requests
//                          go to the bus with lanes shifted and truncated.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int DATA_LEN = 32,
  parameter int OFF_W    = $clog2(DATA_LEN/8)
) (
  input logic        clk,
  input logic        rst_n,
  lsu_ctrl_if.master bus
);

  localparam int STRB_W = DATA_LEN / 8;

  // IDLE: ready for a request; REQ: mem_req asserted until granted;
  // WAIT: granted, waiting for the response; RESP: completion presented.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Request fields captured at accept time
  logic [DATA_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [1:0]          size_q;
  logic                is_store_q;
  logic [DATA_LEN-1:0] pre_data_q;

  logic                accept;
  logic                capture;
  logic                out_hs;
  logic                is_access;
  logic                skip_bus;
  logic [OFF_W-1:0]    off;
  logic [STRB_W-1:0]   base_mask;

  // ---------------------------------------------------------------------------
  // Handshake decodes
  // ---------------------------------------------------------------------------
  // state_q is forced to IDLE while rst_n is low, so the explicit rst_n term
  // is what keeps in_ready low during reset.
  assign accept    = bus.in_valid && rst_n && (state_q == IDLE);
  assign out_hs    = (state_q == RESP) && bus.out_ready;
  // A response arriving together with the grant completes the transaction in
  // the same cycle; otherwise it is only expected in WAIT.
  assign capture   = ((state_q == REQ)  && bus.mem_gnt && bus.mem_rvalid) ||
                     ((state_q == WAIT) && bus.mem_rvalid);
  assign is_access = bus.in_is_load || bus.in_is_store;

`ifdef LSU_MISALIGN_CHECK_EN
  logic in_misalign;
  logic misalign_q;

  always_comb begin
    in_misalign = 1'b0;
    case (bus.in_size)
      2'd1:    in_misalign = bus.in_addr[0];
      2'd2:    in_misalign = (bus.in_addr[1:0] != 2'b00);
      2'd3:    in_misalign = (bus.in_addr[OFF_W-1:0] != '0);
      default: in_misalign = 1'b0;
    endcase
  end

  // Misaligned accesses bypass the bus entirely.
  assign skip_bus = !is_access || in_misalign;
`else
  assign skip_bus = !is_access;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = skip_bus ? RESP : REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_d = bus.mem_rvalid ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and response data
  // ---------------------------------------------------------------------------
  // The request fields are captured once at accept and are what keeps the bus
  // outputs stable for as long as the grant is withheld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'd0;
      is_store_q <= 1'b0;
      pre_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q     <= bus.in_addr;
        wdata_q    <= bus.in_wdata;
        size_q     <= bus.in_size;
        // A request flagged as both load and store is treated as a load.
        is_store_q <= bus.in_is_store && !bus.in_is_load;
        // Cleared here so that skipped requests (no access, misaligned)
        // complete with zero data.
        pre_data_q <= '0;
      end else if (capture) begin
        // Stores report zero; loads return the addressed bytes right-aligned.
        pre_data_q <= is_store_q ? '0 : (bus.mem_rdata >> {off, 3'b000});
      end
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // Set only through accept, so it stays high for the whole RESP phase and
  // drops with the completion handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= in_misalign;
    end else if (out_hs) begin
      misalign_q <= 1'b0;
    end
  end

  assign bus.out_misalign = misalign_q;
`else
  assign bus.out_misalign = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------------
  assign off = addr_q[OFF_W-1:0];

  // For a 32-bit datapath the dword mask truncates to the full strobe width;
  // dword is not a legal size there.
  always_comb begin
    base_mask = '0;
    case (size_q)
      2'd0:    base_mask = STRB_W'(8'h01);
      2'd1:    base_mask = STRB_W'(8'h03);
      2'd2:    base_mask = STRB_W'(8'h0F);
      default: base_mask = STRB_W'(8'hFF);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Bus outputs are driven only while a request is pending so that an idle
  // bus shows all zeros. Shifting left drops any lanes pushed past the top of
  // the word (misaligned accesses in the unchecked build).
  assign bus.in_ready     = rst_n && (state_q == IDLE);
  assign bus.mem_req      = (state_q == REQ);
  assign bus.mem_we       = (state_q == REQ) && is_store_q;
  assign bus.mem_addr     = (state_q == REQ) ? {addr_q[DATA_LEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.mem_wdata    = (state_q == REQ && is_store_q) ? (wdata_q << {off, 3'b000}) : '0;
  assign bus.mem_wstrb    = (state_q == REQ && is_store_q) ? (base_mask << off) : '0;
  assign bus.out_valid    = (state_q == RESP);
  assign bus.out_pre_data = pre_data_q;

endmodule : lsu_ctrl
